// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: round-robin arbiter sharing one 1RW SRAM macro between the
// instruction-fetch port (read-only) and the load/store port (read/write).
// Sub-word stores run as a two-cycle read-modify-write (read, then RMW_WR).
// Optional feature: define SRAM_ARB_PARITY_EN to keep even parity in spare bit 32.
module sram_arb_ctrl #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req,
  input  logic [31:0]             i_addr,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [31:0]             d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    parity_err,
  output logic                    sram_csb0,
  output logic                    sram_web0,
  output logic                    sram_spare_wen0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH:0]     sram_din0,
  input  logic [DATA_WIDTH:0]     sram_dout0
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  state_e                  state_q, state_d;
  port_e                   rr_last_q, rr_last_d;
  logic                    i_rvalid_q;
  logic                    d_rvalid_q;
  logic                    d_rd_q;
  logic [ADDR_WIDTH-1:0]   rmw_addr_q, rmw_addr_d;
  logic [BE_W-1:0]         rmw_be_q, rmw_be_d;
  logic [DATA_WIDTH-1:0]   rmw_wdata_q, rmw_wdata_d;

  logic                    gnt_i_c;
  logic                    gnt_d_c;
  logic                    d_full_wr_c;
  logic                    d_rmw_rd_c;
  logic [ADDR_WIDTH-1:0]   i_word_c;
  logic [ADDR_WIDTH-1:0]   d_word_c;
  logic [DATA_WIDTH-1:0]   merged_c;
  logic [DATA_WIDTH-1:0]   wr_data_c;

  assign i_word_c = i_addr[ADDR_WIDTH+1:2];
  assign d_word_c = d_addr[ADDR_WIDTH+1:2];

  // Round-robin arbitration; grants only in IDLE and never while in reset.
  always_comb begin
    gnt_i_c = 1'b0;
    gnt_d_c = 1'b0;
    if (rst_n && (state_q == ST_IDLE)) begin
      if (i_req && d_req) begin
        if (rr_last_q == PORT_FETCH) gnt_d_c = 1'b1;
        else                         gnt_i_c = 1'b1;
      end else begin
        gnt_i_c = i_req;
        gnt_d_c = d_req;
      end
    end
  end

  assign d_full_wr_c = gnt_d_c & d_we & (d_be == '1);
  assign d_rmw_rd_c  = gnt_d_c & d_we & (d_be != '1);

  // Byte merge of the latched store data over the old word read last cycle.
  always_comb begin
    merged_c = '0;
    for (int unsigned b = 0; b < BE_W; b++) begin
      merged_c[8*b +: 8] = rmw_be_q[b] ? rmw_wdata_q[8*b +: 8] : sram_dout0[8*b +: 8];
    end
  end

  // Macro drive: RMW write-back has priority, then the granted port.
  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    wr_data_c  = '0;
    if (state_q == ST_RMW_WR) begin
      sram_csb0  = 1'b0;
      sram_web0  = 1'b0;
      sram_addr0 = rmw_addr_q;
      wr_data_c  = merged_c;
    end else if (gnt_d_c) begin
      sram_csb0  = 1'b0;
      sram_addr0 = d_word_c;
      if (d_full_wr_c) begin
        sram_web0 = 1'b0;
        wr_data_c = d_wdata;
      end
    end else if (gnt_i_c) begin
      sram_csb0  = 1'b0;
      sram_addr0 = i_word_c;
    end
  end

  // Next-state: round-robin pointer and RMW capture on a sub-word store grant.
  always_comb begin
    state_d     = ST_IDLE;
    rr_last_d   = rr_last_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_be_d    = rmw_be_q;
    rmw_wdata_d = rmw_wdata_q;
    if (gnt_i_c)      rr_last_d = PORT_FETCH;
    else if (gnt_d_c) rr_last_d = PORT_DATA;
    if (d_rmw_rd_c) begin
      state_d     = ST_RMW_WR;
      rmw_addr_d  = d_word_c;
      rmw_be_d    = d_be;
      rmw_wdata_d = d_wdata;
    end
  end

  // State, pointer, response flags and RMW latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= PORT_FETCH;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rd_q      <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_be_q    <= '0;
      rmw_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      i_rvalid_q  <= gnt_i_c;
      d_rvalid_q  <= gnt_d_c;
      d_rd_q      <= gnt_d_c & ~d_full_wr_c;
      rmw_addr_q  <= rmw_addr_d;
      rmw_be_q    <= rmw_be_d;
      rmw_wdata_q <= rmw_wdata_d;
    end
  end

  assign i_gnt    = gnt_i_c;
  assign d_gnt    = gnt_d_c;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  // Read data is only valid the cycle after the grant; full-word stores return 0.
  assign i_rdata  = i_rvalid_q ? sram_dout0[DATA_WIDTH-1:0] : '0;
  assign d_rdata  = d_rd_q     ? sram_dout0[DATA_WIDTH-1:0] : '0;

`ifdef SRAM_ARB_PARITY_EN
  logic rd_rsp_c;
  assign rd_rsp_c        = i_rvalid_q | d_rd_q;
  assign sram_din0       = {^wr_data_c, wr_data_c};
  assign sram_spare_wen0 = ~sram_csb0 & ~sram_web0;
  assign parity_err      = rd_rsp_c & (^sram_dout0);
`else
  logic unused_spare_c;
  assign sram_din0       = {1'b0, wr_data_c};
  assign sram_spare_wen0 = 1'b0;
  assign parity_err      = 1'b0;
  assign unused_spare_c  = sram_dout0[DATA_WIDTH];
`endif

  // Byte-offset and out-of-range address bits are intentionally ignored.
  logic unused_addr_c;
  assign unused_addr_c = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0],
                           d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

endmodule
